// File: rtl/xor16_descrambler.sv
// Receive-side XOR16 descrambler: XORs each accepted word with a 16-bit LFSR keystream word
// and presents the result through a single-entry valid/ready output register.
module xor16_descrambler #(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_load,
   input  logic [15:0]      seed_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [CNT_W-1:0] word_cnt
);

   localparam int unsigned DATA_W = 16;

   // Sixteen serial Fibonacci steps (x^16+x^14+x^13+x^11+1) unrolled into one clock.
   function automatic logic [DATA_W-1:0] step16(input logic [DATA_W-1:0] s);
      logic [DATA_W-1:0] v;
      v = s;
      for (int i = 0; i < 16; i++) begin
         v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
      end
      return v;
   endfunction

   logic [DATA_W-1:0] r_lfsr;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic [CNT_W-1:0]  r_word_cnt;

   logic              w_accept;
   logic [DATA_W-1:0] w_lfsr_next;
   logic [DATA_W-1:0] w_seed;

   // Output slot is free when empty or being drained this cycle.
   assign in_ready    = !rst && !seed_load && (!r_out_valid || out_ready);
   assign w_accept    = in_valid && in_ready;
   assign w_lfsr_next = step16(r_lfsr);
   // A zero seed would lock the LFSR up, so it falls back to SEED.
   assign w_seed      = (seed_in == '0) ? SEED : seed_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr      <= SEED;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_word_cnt  <= '0;
      end else if (seed_load) begin
         r_lfsr      <= w_seed;
         r_out_valid <= 1'b0;
         r_word_cnt  <= '0;
      end else if (w_accept) begin
         r_out_data  <= in_data ^ r_lfsr;
         r_out_valid <= 1'b1;
         r_lfsr      <= w_lfsr_next;
         r_word_cnt  <= r_word_cnt + CNT_W'(1);
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_xor16_descrambler.sv
// Scoreboard bench for xor16_descrambler: driver keeps a keystream/occupancy model and queues
// expected words; an independent monitor pops and compares each delivered word.
module tb_xor16_descrambler;

   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst, seed_load, in_valid, out_ready;
   logic [15:0] seed_in, in_data;
   logic        in_ready, out_valid;
   logic [15:0] out_data;
   logic [15:0] word_cnt;

   xor16_descrambler #(.SEED(SEED), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   int unsigned n_vec  = 0;
   int unsigned n_fail = 0;
   logic [15:0] exp_q[$];
   bit          started = 0;

   // Reference model state
   logic [15:0] m_lfsr;
   logic        m_full;
   logic [15:0] m_data;
   logic [15:0] m_cnt;

   // Keystream advance: 16 shifts, feedback = parity of taps 15,13,12,10.
   function automatic logic [15:0] ks_next(input logic [15:0] s);
      logic [15:0] v;
      v = s;
      for (int i = 0; i < 16; i++) v = {v[14:0], ^(v & 16'hB400)};
      return v;
   endfunction

   function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: a word leaves on every cycle with out_valid && out_ready.
   always @(negedge clk) begin
      if (started && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_word: got %h expected none at %0t", out_data, $time);
         end else begin
            chk("scoreboard_word", out_data, exp_q.pop_front());
         end
      end
   end

   // One clock: apply inputs, check visible state, then advance the model at the edge.
   task automatic cycle(input logic r, input logic sl, input logic [15:0] sd,
                        input logic v, input logic [15:0] d, input logic ordy);
      logic exp_rdy;
      rst = r; seed_load = sl; seed_in = sd; in_valid = v; in_data = d; out_ready = ordy;
      exp_rdy = !r && !sl && (!m_full || ordy);
      @(negedge clk);
      chk("in_ready", 16'(in_ready), 16'(exp_rdy));
      chk("out_valid", 16'(out_valid), 16'(m_full));
      chk("out_data", out_data, m_data);
      chk("word_cnt", word_cnt, m_cnt);
      @(posedge clk);
      if (r) begin
         m_lfsr = SEED; m_full = 0; m_data = '0; m_cnt = '0; exp_q.delete();
      end else if (sl) begin
         m_lfsr = (sd == 16'h0) ? SEED : sd; m_full = 0; m_cnt = '0; exp_q.delete();
      end else if (v && exp_rdy) begin
         m_data = d ^ m_lfsr;
         exp_q.push_back(m_data);
         m_full = 1; m_lfsr = ks_next(m_lfsr); m_cnt = m_cnt + 16'd1;
      end else if (ordy) begin
         m_full = 0;
      end
      #1;
   endtask

   task automatic idle(input logic ordy);
      cycle(0, 0, 16'h0, 0, 16'h0, ordy);
   endtask

   initial begin
      logic [15:0] plain[4];
      logic [15:0] k;
      plain[0] = 16'hFF00; plain[1] = 16'h0000; plain[2] = 16'hFFFF; plain[3] = 16'h1234;
      rst = 1; seed_load = 0; seed_in = 0; in_valid = 0; in_data = 0; out_ready = 0;
      @(posedge clk);
      m_lfsr = SEED; m_full = 0; m_data = '0; m_cnt = '0;
      #1;
      started = 1;

      // Reset held for two cycles, then release
      cycle(1, 0, 16'h0, 1, 16'h5555, 1);
      cycle(1, 0, 16'h0, 1, 16'h5555, 1);
      idle(1);

      // Three zero words expose the raw keystream
      cycle(0, 0, 16'h0, 1, 16'h0000, 1);
      chk("first_keystream", out_data, 16'hACE1);
      cycle(0, 0, 16'h0, 1, 16'h0000, 1);
      cycle(0, 0, 16'h0, 1, 16'h0000, 1);
      idle(1);
      chk("cnt_after_3", word_cnt, 16'd3);

      // Round trip from SEED
      cycle(1, 0, 16'h0, 0, 16'h0, 1);
      k = SEED;
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 16'h0, 1, plain[i] ^ k, 1);
         chk("round_trip", out_data, plain[i]);
         k = ks_next(k);
      end
      idle(1);

      // Backpressure: A accepted, B stalled for three cycles, then both drain
      cycle(0, 0, 16'h0, 1, 16'hAAAA, 0);
      cycle(0, 0, 16'h0, 1, 16'hBBBB, 0);
      cycle(0, 0, 16'h0, 1, 16'hBBBB, 0);
      cycle(0, 0, 16'h0, 1, 16'hBBBB, 0);
      cycle(0, 0, 16'h0, 1, 16'hBBBB, 1);
      idle(1);
      idle(1);

      // Resync with seed 1 while a word is offered
      for (int i = 0; i < 5; i++) cycle(0, 0, 16'h0, 1, 16'($urandom), 1);
      cycle(0, 1, 16'h0001, 1, 16'h7777, 1);
      chk("resync_cnt", word_cnt, 16'd0);
      cycle(0, 0, 16'h0, 1, 16'h0000, 1);
      chk("resync_word", out_data, 16'h0001);
      idle(1);

      // Zero seed falls back to SEED; reset drops a held word
      cycle(0, 1, 16'h0000, 0, 16'h0, 1);
      cycle(0, 0, 16'h0, 1, 16'h0000, 0);
      chk("zero_seed_word", out_data, 16'hACE1);
      cycle(1, 0, 16'h0, 1, 16'h1111, 0);
      chk("reset_drop_valid", 16'(out_valid), 16'h0);
      cycle(0, 0, 16'h0, 1, 16'h0000, 1);
      chk("post_reset_word", out_data, 16'hACE1);
      idle(1);

      // Random traffic with occasional resync and reset
      for (int i = 0; i < 400; i++) begin
         automatic logic r  = ($urandom_range(0, 99) == 0);
         automatic logic sl = ($urandom_range(0, 39) == 0);
         automatic logic [15:0] sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         cycle(r, sl, sd, 1'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
      end
      idle(1);
      idle(1);

      n_vec++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
